// File: rtl/decoder_3to8_pkg.sv
// Shared decode constants and the enable/select to one-hot helper.
// Reusable by any binary-to-one-hot decoder leaf.
package decoder_3to8_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OUT_N = 8;

    // Bit 'sel' follows 'en'; all other bits stay low.
    function automatic logic [OUT_N-1:0] decode_onehot(input logic             en,
                                                       input logic [SEL_W-1:0] sel);
        logic [OUT_N-1:0] v;
        v      = '0;
        v[sel] = en;
        return v;
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Purely combinational 3-to-8 decode of enable and select into an active-high one-hot vector.
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [OUT_N-1:0] o_dec
);

    assign o_dec = decode_onehot(i_en, i_sel);

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 decoder: core decode, optional output register with async reset, optional inversion,
// and fan-out of the vector onto the individual output pins.
module decoder_3to8
    import decoder_3to8_pkg::*;
#(
    parameter bit REG_OUT        = 1'b1,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic E,
    output logic O0,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    output logic O5,
    output logic O6,
    output logic O7
);

    logic [SEL_W-1:0] w_sel;
    logic [OUT_N-1:0] w_dec;
    logic [OUT_N-1:0] w_stage;
    logic [OUT_N-1:0] w_out;

    assign w_sel = {B2, B1, B0};

    decoder_3to8_core u_core (
        .i_en  (E),
        .i_sel (w_sel),
        .o_dec (w_dec)
    );

    if (REG_OUT) begin : g_reg
        logic [OUT_N-1:0] r_dec;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dec <= '0;
            end else begin
                r_dec <= w_dec;
            end
        end

        assign w_stage = r_dec;
    end else begin : g_comb
        // Clock and reset have no load in bypass mode.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;
        assign w_stage          = w_dec;
    end

    // Inverting after the register also inverts the reset value to all ones.
    assign w_out = w_stage ^ {OUT_N{OUT_ACTIVE_LOW}};

    assign {O7, O6, O5, O4, O3, O2, O1, O0} = w_out;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench: registered, combinational and active-low instances share one stimulus stream.
module tb_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       E   = 1'b0;
    logic [2:0] sel = 3'd0;

    wire  [7:0] q_reg;
    wire  [7:0] q_comb;
    wire  [7:0] q_al;

    always #5 clk = ~clk;

    decoder_3to8 #(.REG_OUT(1'b1), .OUT_ACTIVE_LOW(1'b0)) u_reg (
        .clk (clk), .rst (rst), .B0 (sel[0]), .B1 (sel[1]), .B2 (sel[2]), .E (E),
        .O0 (q_reg[0]), .O1 (q_reg[1]), .O2 (q_reg[2]), .O3 (q_reg[3]),
        .O4 (q_reg[4]), .O5 (q_reg[5]), .O6 (q_reg[6]), .O7 (q_reg[7])
    );

    decoder_3to8 #(.REG_OUT(1'b0), .OUT_ACTIVE_LOW(1'b0)) u_comb (
        .clk (clk), .rst (rst), .B0 (sel[0]), .B1 (sel[1]), .B2 (sel[2]), .E (E),
        .O0 (q_comb[0]), .O1 (q_comb[1]), .O2 (q_comb[2]), .O3 (q_comb[3]),
        .O4 (q_comb[4]), .O5 (q_comb[5]), .O6 (q_comb[6]), .O7 (q_comb[7])
    );

    decoder_3to8 #(.REG_OUT(1'b1), .OUT_ACTIVE_LOW(1'b1)) u_al (
        .clk (clk), .rst (rst), .B0 (sel[0]), .B1 (sel[1]), .B2 (sel[2]), .E (E),
        .O0 (q_al[0]), .O1 (q_al[1]), .O2 (q_al[2]), .O3 (q_al[3]),
        .O4 (q_al[4]), .O5 (q_al[5]), .O6 (q_al[6]), .O7 (q_al[7])
    );

    typedef struct {
        string      name;
        logic [7:0] exp_reg;
        logic [7:0] exp_comb;
    } chk_t;

    chk_t       q_sync[$];
    chk_t       q_now[$];
    event       ev_now;
    bit         done   = 1'b0;
    int         n_vec  = 0;
    int         n_err  = 0;
    logic [7:0] cur    = 8'h00;

    // ---------------- monitor ----------------
    function automatic void cmp(string name, string which, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %02h expected %02h at %0t", name, which, act, exp, $time);
        end
    endfunction

    function automatic void compare(chk_t c);
        logic [7:0] exp_al;
        exp_al = ~c.exp_reg;
        cmp(c.name, "reg", q_reg, c.exp_reg);
        cmp(c.name, "active_low", q_al, exp_al);
        cmp(c.name, "comb", q_comb, c.exp_comb);
    endfunction

    initial begin
        forever begin
            @(posedge clk or ev_now);
            #1;
            // Immediate checks are only queued between edges, so a non-empty q_now marks them.
            if (q_now.size() > 0) begin
                while (q_now.size() > 0) compare(q_now.pop_front());
            end else if (q_sync.size() > 0) begin
                compare(q_sync.pop_front());
            end
            if (done && q_sync.size() == 0 && q_now.size() == 0) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic now_check(string name, logic [7:0] er, logic [7:0] ec);
        chk_t c;
        c.name     = name;
        c.exp_reg  = er;
        c.exp_comb = ec;
        q_now.push_back(c);
        ->ev_now;
    endtask

    task automatic expect_edge(string name, logic [7:0] exp);
        chk_t c;
        c.name     = name;
        c.exp_reg  = exp;
        c.exp_comb = exp;
        q_sync.push_back(c);
        cur = exp;
    endtask

    // Drive at negedge; mid-cycle the register must still hold the previous decode.
    task automatic step(string name, bit e, logic [2:0] s, logic [7:0] exp);
        @(negedge clk);
        E   = e;
        sel = s;
        #1;
        now_check({name, "_mid"}, cur, exp);
        expect_edge(name, exp);
    endtask

    logic [7:0] en_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] tg_tbl [3] = '{8'h08, 8'h00, 8'h08};
    bit         tg_en  [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        #1;
        E   = 1'b1;
        sel = 3'd5;
        rst = 1'b1;
        #2;
        now_check("rst_async", 8'h00, 8'h20);

        @(negedge clk);
        rst = 1'b0;
        expect_edge("rst_release", 8'h20);

        for (int i = 0; i < 8; i++) step("en_sweep", 1'b1, 3'(i), en_tbl[i]);
        for (int i = 0; i < 8; i++) step("dis_sweep", 1'b0, 3'(i), 8'h00);
        for (int i = 0; i < 3; i++) step("en_toggle", tg_en[i], 3'd3, tg_tbl[i]);
        step("sel2", 1'b1, 3'd2, 8'h04);

        step("pre_rst", 1'b1, 3'd7, 8'h80);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        now_check("rst_mid", 8'h00, 8'h80);
        @(negedge clk);
        rst = 1'b0;
        expect_edge("rst_mid_release", 8'h80);

        step("post_rst", 1'b1, 3'd2, 8'h04);
        step("both_change", 1'b0, 3'd6, 8'h00);
        step("both_change2", 1'b1, 3'd1, 8'h02);
        done = 1'b1;
    end

endmodule
